plab4_net_router_output_ctrl: RTL and testbench

//  Control for one ring-router output port (west, terminal or east). Round-robin

---
 rtl/plab4_net_router_output_ctrl.sv | 105 ++++++++++
 tb/tb_plab4_net_router_output_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/plab4_net_router_output_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : plab4_net_router_output_ctrl                                    |
// | Purpose  : Ring-router output-port control: round-robin arbitration over   |
// |            three input ctrls plus a downstream credit counter.             |
// | Options  : PLAB4_NET_OUT_CTRL_STALL_CNT_EN adds a saturating stall counter. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module plab4_net_router_output_ctrl #(
    parameter int p_num_credits    = 3,
    parameter int p_num_free_nbits = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2:0]                  reqs,
    output logic [2:0]                  grants,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [1:0]                  xbar_sel,
    input  logic                        credit_return,
`ifdef PLAB4_NET_OUT_CTRL_STALL_CNT_EN
    output logic [15:0]                 stall_count,
`endif
    output logic [p_num_free_nbits-1:0] num_free
);

    localparam logic [p_num_free_nbits-1:0] C_CREDITS_MAX = p_num_free_nbits'(p_num_credits);
    localparam logic [p_num_free_nbits-1:0] C_CREDIT_ONE  = p_num_free_nbits'(1);
    localparam logic [p_num_free_nbits-1:0] C_CREDIT_ZERO = '0;

    logic [p_num_free_nbits-1:0] r_credits;
    logic [1:0]                  r_ptr;
    logic                        w_can_send;
    logic                        w_fire;
    logic                        w_found;
    int                          w_idx;

    assign w_can_send = out_rdy && (r_credits != C_CREDIT_ZERO);

    // Search starts at the pointer and wraps modulo 3; first requester wins.
    always_comb begin
        grants   = 3'b000;
        xbar_sel = 2'd0;
        w_found  = 1'b0;
        w_idx    = 0;
        if (w_can_send) begin
            for (int k = 0; k < 3; k++) begin
                w_idx = (int'(r_ptr) + k) % 3;
                if (!w_found && reqs[w_idx]) begin
                    grants[w_idx] = 1'b1;
                    xbar_sel      = 2'(w_idx);
                    w_found       = 1'b1;
                end
            end
        end
    end

    assign out_val  = |grants;
    assign w_fire   = out_val && out_rdy;
    assign num_free = r_credits;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 2'd0;
        end else if (w_fire) begin
            r_ptr <= (xbar_sel == 2'd2) ? 2'd0 : xbar_sel + 2'd1;
        end
    end

    // A return arriving while already full is dropped rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credits <= C_CREDITS_MAX;
        end else begin
            case ({w_fire, credit_return})
                2'b10:   r_credits <= r_credits - C_CREDIT_ONE;
                2'b01:   if (r_credits != C_CREDITS_MAX) r_credits <= r_credits + C_CREDIT_ONE;
                default: r_credits <= r_credits;
            endcase
        end
    end

`ifdef PLAB4_NET_OUT_CTRL_STALL_CNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 16'd0;
        end else if ((|reqs) && !w_fire && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && credit_return && !w_fire && (r_credits == C_CREDITS_MAX))
            $display("%m: error: credit_return with credits already full, value held");
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_plab4_net_router_output_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_plab4_net_router_output_ctrl                                 |
// | Purpose  : Directed self-checking bench for the router output control.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_plab4_net_router_output_ctrl;

    logic       clk;
    logic       reset;
    logic [2:0] reqs;
    logic [2:0] grants;
    logic       out_val;
    logic       out_rdy;
    logic [1:0] xbar_sel;
    logic       credit_return;
    logic [1:0] num_free;
`ifdef PLAB4_NET_OUT_CTRL_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int n_tests;
    int n_failed;

    plab4_net_router_output_ctrl #(
        .p_num_credits    (3),
        .p_num_free_nbits (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .reqs          (reqs),
        .grants        (grants),
        .out_val       (out_val),
        .out_rdy       (out_rdy),
        .xbar_sel      (xbar_sel),
        .credit_return (credit_return),
`ifdef PLAB4_NET_OUT_CTRL_STALL_CNT_EN
        .stall_count   (stall_count),
`endif
        .num_free      (num_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reqs          = 3'b000;
        credit_return = 1'b0;
        reset         = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_tests       = 0;
        n_failed      = 0;
        reqs          = 3'b000;
        out_rdy       = 1'b0;
        credit_return = 1'b0;
        reset         = 1'b0;
        #2;
        do_reset();

        // Reset state
        settle();
        check("rst_num_free", int'(num_free), 3);
        check("rst_grants",   int'(grants),   0);
        check("rst_out_val",  int'(out_val),  0);
        check("rst_xbar_sel", int'(xbar_sel), 0);

        // 1: round robin drains all credits
        reqs = 3'b111; out_rdy = 1'b1;
        settle();
        check("t1_g0",  int'(grants),   1);
        check("t1_x0",  int'(xbar_sel), 0);
        check("t1_v0",  int'(out_val),  1);
        tick();
        check("t1_nf1", int'(num_free), 2);
        check("t1_g1",  int'(grants),   2);
        check("t1_x1",  int'(xbar_sel), 1);
        tick();
        check("t1_nf2", int'(num_free), 1);
        check("t1_g2",  int'(grants),   4);
        check("t1_x2",  int'(xbar_sel), 2);
        tick();
        check("t1_nf3", int'(num_free), 0);
        check("t1_g3",  int'(grants),   0);
        check("t1_v3",  int'(out_val),  0);
        tick();
        check("t1_nf4", int'(num_free), 0);
        check("t1_g4",  int'(grants),   0);

        // 2: one credit comes back
        reqs = 3'b000; credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        reqs = 3'b010;
        settle();
        check("t2_nf",  int'(num_free), 1);
        check("t2_g",   int'(grants),   2);
        check("t2_x",   int'(xbar_sel), 1);
        tick();
        check("t2_nf0", int'(num_free), 0);

        // 3: downstream stalls for four cycles
        do_reset();
        reqs = 3'b101; out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t3_stall_g", int'(grants),  0);
            check("t3_stall_v", int'(out_val), 0);
            tick();
        end
        check("t3_nf_hold", int'(num_free), 3);
        out_rdy = 1'b1;
        settle();
`ifdef PLAB4_NET_OUT_CTRL_STALL_CNT_EN
        check("t3_stall_cnt", int'(stall_count), 4);
`endif
        check("t3_first_g", int'(grants), 1);
        tick();
        check("t3_nf", int'(num_free), 2);

        // 4: fire and credit return together at num_free=2 (ptr=1 -> winner 2)
        reqs = 3'b101; credit_return = 1'b1;
        settle();
        check("t4_g", int'(grants), 4);
        tick();
        credit_return = 1'b0;
        reqs = 3'b111;
        settle();
        check("t4_nf",     int'(num_free), 2);
        check("t4_ptr_g",  int'(grants),   1);

        // 5: credit return while full saturates
        reqs = 3'b000; credit_return = 1'b1;
        tick();
        settle();
        check("t5_nf_full", int'(num_free), 3);
        tick();
        credit_return = 1'b0;
        settle();
        check("t5_nf_sat", int'(num_free), 3);

        // 6: reset mid-operation with num_free=1, ptr=2
        reqs = 3'b111;
        tick();
        tick();
        settle();
        check("t6_nf_pre", int'(num_free), 1);
        check("t6_g_pre",  int'(grants),   4);
        reqs = 3'b000; reset = 1'b1;
        tick();
        reset = 1'b0;
        reqs = 3'b111;
        settle();
        check("t6_nf_post", int'(num_free), 3);
        check("t6_g_post",  int'(grants),   1);
        check("t6_x_post",  int'(xbar_sel), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1 (bench did not finish)");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
